histogram_level_scanner: RTL

Sits directly downstream of the grayscale histogram.
- During vertical blanking it sweeps all bins through the histogram read port (rd_en / rd_addr / rd_data) in two passes: pass 1 totals the pixel count, pass 2 finds low/high percentile grey levels.
- Publishes the results for the auto-exposure / contrast-stretch logic, then pulses the histogram clear so the next frame starts from zero.

---
 rtl/histogram_level_scanner.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/histogram_level_scanner.sv
// Vertical-blanking scanner: two passes over the grey-level histogram give the pixel total and the
// low/high percentile levels, then the histogram is cleared. Define HIST_MEAN_EN to add mean_level.
module histogram_level_scanner #(
    parameter int BINS_LOG2 = 10,
    parameter int CNT_W     = 16,
    parameter int LOW_NUM   = 13,
    parameter int HIGH_NUM  = 243
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         frame_valid,
    output logic                         hist_rd_en,
    output logic [BINS_LOG2-1:0]         hist_rd_addr,
    input  logic [CNT_W-1:0]             hist_rd_data,
    output logic                         hist_clear,
    output logic [CNT_W+BINS_LOG2-1:0]   pixel_count,
    output logic [BINS_LOG2-1:0]         low_level,
    output logic [BINS_LOG2-1:0]         high_level,
`ifdef HIST_MEAN_EN
    output logic [BINS_LOG2-1:0]         mean_level,
`endif
    output logic                         stats_valid,
    output logic                         busy,
    output logic                         abort
);
    localparam int ACC_W = CNT_W + BINS_LOG2;
    localparam int PRD_W = ACC_W + 9;
    localparam logic [BINS_LOG2-1:0] MAX_BIN = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_SUM, S_CALC,
`ifdef HIST_MEAN_EN
        S_DIV,
`endif
        S_SCAN, S_CLEAR, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic                 fv_q, fv_rise, fv_fall;
    logic [BINS_LOG2-1:0] addr, rd_idx_q, low_cand, high_cand;
    logic                 drain, rd_vld_q, low_found, high_found, sweeping;
    logic [ACC_W-1:0]     total, cum, cum_nxt, low_thr, high_thr;
    logic [PRD_W-1:0]     low_prod, high_prod;

    assign fv_rise  = ~fv_q & frame_valid;
    assign fv_fall  = fv_q & ~frame_valid;
    assign sweeping = (state == S_SUM) || (state == S_SCAN);

    // A rising frame_valid kills the read in the same cycle the abort is taken.
    assign hist_rd_en   = sweeping & ~drain & ~fv_rise;
    assign hist_rd_addr = addr;
    assign hist_clear   = (state == S_CLEAR);
    assign stats_valid  = (state == S_DONE);
    assign busy         = (state != S_IDLE);

    assign cum_nxt   = cum + ACC_W'(hist_rd_data);
    assign low_prod  = PRD_W'(total) * PRD_W'(LOW_NUM);
    assign high_prod = PRD_W'(total) * PRD_W'(HIGH_NUM);

`ifdef HIST_MEAN_EN
    localparam int WGT_W = CNT_W + 2 * BINS_LOG2;
    localparam int DC_W  = $clog2(BINS_LOG2 + 1);
    logic [WGT_W-1:0]     weighted, rem, dsr;
    logic [BINS_LOG2-1:0] quot;
    logic [DC_W-1:0]      div_left;
    logic                 rem_ge;
    assign rem_ge = (rem >= dsr);
`endif

    // NOTE: every output of this process gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fv_fall) state_nxt = S_SUM;
            S_SUM:   if (fv_rise) state_nxt = S_IDLE; else if (drain) state_nxt = S_CALC;
`ifdef HIST_MEAN_EN
            S_CALC:  state_nxt = fv_rise ? S_IDLE : S_DIV;
            S_DIV:   if (fv_rise) state_nxt = S_IDLE; else if (div_left == '0) state_nxt = S_SCAN;
`else
            S_CALC:  state_nxt = fv_rise ? S_IDLE : S_SCAN;
`endif
            S_SCAN:  if (fv_rise) state_nxt = S_IDLE; else if (drain) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            fv_q        <= 1'b0;
            abort       <= 1'b0;
            addr        <= '0;
            drain       <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_idx_q    <= '0;
            total       <= '0;
            cum         <= '0;
            low_thr     <= '0;
            high_thr    <= '0;
            low_found   <= 1'b0;
            high_found  <= 1'b0;
            low_cand    <= MAX_BIN;
            high_cand   <= MAX_BIN;
            pixel_count <= '0;
            low_level   <= '0;
            high_level  <= MAX_BIN;
`ifdef HIST_MEAN_EN
            weighted    <= '0;
            rem         <= '0;
            dsr         <= '0;
            quot        <= '0;
            div_left    <= '0;
            mean_level  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            fv_q     <= frame_valid;
            abort    <= busy && (state != S_CLEAR) && (state != S_DONE) && fv_rise;
            rd_vld_q <= hist_rd_en;
            rd_idx_q <= addr;

            if (hist_rd_en) begin
                addr <= addr + 1'b1;
                if (addr == MAX_BIN) drain <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    addr  <= '0;
                    drain <= 1'b0;
                    total <= '0;
`ifdef HIST_MEAN_EN
                    weighted <= '0;
`endif
                end
                S_SUM: if (rd_vld_q) begin
                    total <= total + ACC_W'(hist_rd_data);
`ifdef HIST_MEAN_EN
                    weighted <= weighted + WGT_W'(rd_idx_q) * WGT_W'(hist_rd_data);
`endif
                end
                S_CALC: begin
                    low_thr    <= low_prod[ACC_W+7:8];
                    high_thr   <= high_prod[ACC_W+7:8];
                    cum        <= '0;
                    low_found  <= 1'b0;
                    high_found <= 1'b0;
                    low_cand   <= MAX_BIN;
                    high_cand  <= MAX_BIN;
                    addr       <= '0;
                    drain      <= 1'b0;
`ifdef HIST_MEAN_EN
                    rem      <= weighted;
                    dsr      <= WGT_W'(total) << (BINS_LOG2 - 1);
                    quot     <= '0;
                    div_left <= DC_W'(BINS_LOG2 - 1);
`endif
                end
`ifdef HIST_MEAN_EN
                // Quotient is known to fit BINS_LOG2 bits, so only that many restoring steps are needed.
                S_DIV: begin
                    if (rem_ge) rem <= rem - dsr;
                    dsr      <= dsr >> 1;
                    quot     <= {quot[BINS_LOG2-2:0], rem_ge};
                    div_left <= div_left - 1'b1;
                end
`endif
                S_SCAN: if (rd_vld_q) begin
                    cum <= cum_nxt;
                    if (!low_found && cum_nxt > low_thr) begin
                        low_found <= 1'b1;
                        low_cand  <= rd_idx_q;
                    end
                    if (!high_found && cum_nxt > high_thr) begin
                        high_found <= 1'b1;
                        high_cand  <= rd_idx_q;
                    end
                end
                S_CLEAR: begin
                    pixel_count <= total;
                    low_level   <= (total == '0) ? '0 : low_cand;
                    high_level  <= high_cand;
`ifdef HIST_MEAN_EN
                    mean_level  <= (total == '0) ? '0 : quot;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
